// File: rtl/sort_stream_pkg.sv
// Shared types and helpers for the sort_stream packet sorter.
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic SORT_ASC  = 1'b0;
  localparam logic SORT_DESC = 1'b1;

  function automatic int cnt_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/sort_stream_if.sv
// Sink/source stream bundle for sort_stream; optional src_length when SORT_LENGTH_EN is defined.
interface sort_stream_if #(
  parameter int DATA_WIDTH = 16
`ifdef SORT_LENGTH_EN
  , parameter int MAX_LENGTH = 128
`endif
);

  logic                  snk_ready;
  logic                  snk_valid;
  logic                  snk_sop;
  logic                  snk_eop;
  logic [DATA_WIDTH-1:0] snk_data;
  logic                  sort_order;
  logic                  src_ready;
  logic                  src_valid;
  logic                  src_sop;
  logic                  src_eop;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_error;
`ifdef SORT_LENGTH_EN
  logic [sort_pkg::cnt_w(MAX_LENGTH)-1:0] src_length;
`endif

  // master drives packets in and consumes the sorted stream
  modport master (
`ifdef SORT_LENGTH_EN
    input  src_length,
`endif
    input  snk_ready, src_valid, src_sop, src_eop, src_data, src_error,
    output snk_valid, snk_sop, snk_eop, snk_data, sort_order, src_ready
  );

  modport slave (
`ifdef SORT_LENGTH_EN
    output src_length,
`endif
    output snk_ready, src_valid, src_sop, src_eop, src_data, src_error,
    input  snk_valid, snk_sop, snk_eop, snk_data, sort_order, src_ready
  );

endinterface

// File: rtl/sort_stream_cell.sv
// One slot of the systolic insertion array: entry + valid, with insert, clear and shift-out.
module sort_cell
  import sort_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter bit IS_HEAD    = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i_ins,
  input  logic                  i_clr,
  input  logic                  i_shift,
  input  logic                  i_order,
  input  logic [DATA_WIDTH-1:0] i_x,
  input  logic [DATA_WIDTH-1:0] i_up_e,
  input  logic                  i_up_vld,
  input  logic                  i_up_keep,
  input  logic [DATA_WIDTH-1:0] i_dn_e,
  input  logic                  i_dn_vld,
  output logic [DATA_WIDTH-1:0] o_e,
  output logic                  o_vld,
  output logic                  o_keep
);

  logic [DATA_WIDTH-1:0] r_e;
  logic                  r_vld;

  // ties keep the earlier arrival in place, which makes the sort stable
  assign o_keep = r_vld && ((i_order == SORT_DESC) ? (r_e >= i_x) : (r_e <= i_x));
  assign o_e    = r_e;
  assign o_vld  = r_vld;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_e   <= '0;
      r_vld <= 1'b0;
    end else if (i_clr) begin
      if (IS_HEAD) begin
        r_e   <= i_x;
        r_vld <= 1'b1;
      end else begin
        r_vld <= 1'b0;
      end
    end else if (i_ins && !o_keep) begin
      if (IS_HEAD || i_up_keep) begin
        r_e   <= i_x;
        r_vld <= 1'b1;
      end else begin
        r_e   <= i_up_e;
        r_vld <= i_up_vld;
      end
    end else if (i_shift) begin
      r_e   <= i_dn_e;
      r_vld <= i_dn_vld;
    end
  end

endmodule

// File: rtl/sort_stream.sv
// Single-clock streaming packet sorter: insertion-sorts a packet on the way in, drains it after eop.
// Optional SORT_LENGTH_EN adds src_length (word count of the emitted packet, saturated).
module sort_stream
  import sort_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LENGTH = 128
) (
  input  logic          clock,
  input  logic          reset_n,
  sort_stream_if.slave  s
);

  localparam int              CNT_W   = cnt_w(MAX_LENGTH);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LENGTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_order, w_order_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_first, w_first_nxt;
  logic             w_acc, w_ins, w_clr, w_shift, w_drain, w_snk_rdy;

  logic [MAX_LENGTH-1:0][DATA_WIDTH-1:0] w_e, w_up_e, w_dn_e;
  logic [MAX_LENGTH-1:0]                 w_vld, w_keep, w_up_vld, w_up_keep, w_dn_vld;

  assign w_drain   = (r_state == DRAIN);
  assign w_snk_rdy = !w_drain;
  assign w_acc     = s.snk_valid && w_snk_rdy;

  // slot 0 ignores its upstream inputs, so wrapping the tail around is harmless
  assign w_up_e    = {w_e[MAX_LENGTH-2:0], w_e[MAX_LENGTH-1]};
  assign w_up_vld  = {w_vld[MAX_LENGTH-2:0], w_vld[MAX_LENGTH-1]};
  assign w_up_keep = {w_keep[MAX_LENGTH-2:0], w_keep[MAX_LENGTH-1]};
  assign w_dn_e    = {DATA_WIDTH'(0), w_e[MAX_LENGTH-1:1]};
  assign w_dn_vld  = {1'b0, w_vld[MAX_LENGTH-1:1]};

  for (genvar gi = 0; gi < MAX_LENGTH; gi++) begin : g_cell
    sort_cell #(
      .DATA_WIDTH(DATA_WIDTH),
      .IS_HEAD   (gi == 0)
    ) u_cell (
      .clock    (clock),
      .reset_n  (reset_n),
      .i_ins    (w_ins),
      .i_clr    (w_clr),
      .i_shift  (w_shift),
      .i_order  (r_order),
      .i_x      (s.snk_data),
      .i_up_e   (w_up_e[gi]),
      .i_up_vld (w_up_vld[gi]),
      .i_up_keep(w_up_keep[gi]),
      .i_dn_e   (w_dn_e[gi]),
      .i_dn_vld (w_dn_vld[gi]),
      .o_e      (w_e[gi]),
      .o_vld    (w_vld[gi]),
      .o_keep   (w_keep[gi])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_order_nxt = r_order;
    w_ovf_nxt   = r_ovf;
    w_first_nxt = r_first;
    w_ins       = 1'b0;
    w_clr       = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE, LOAD: begin
        w_first_nxt = 1'b1;
        if (w_acc) begin
          // sop always (re)starts a packet; a stray non-sop beat in IDLE is dropped
          if (s.snk_sop) begin
            w_clr       = 1'b1;
            w_order_nxt = s.sort_order;
            w_cnt_nxt   = ONE;
            w_ovf_nxt   = 1'b0;
            w_state_nxt = s.snk_eop ? DRAIN : LOAD;
          end else if (r_state == LOAD) begin
            w_ins = 1'b1;
            if (r_cnt == MAX_CNT) w_ovf_nxt = 1'b1;
            else                  w_cnt_nxt = r_cnt + ONE;
            if (s.snk_eop) w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (s.src_ready) begin
          w_shift     = 1'b1;
          w_first_nxt = 1'b0;
          w_cnt_nxt   = r_cnt - ONE;
          if (r_cnt == ONE) begin
            w_state_nxt = IDLE;
            w_ovf_nxt   = 1'b0;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_order <= SORT_ASC;
      r_ovf   <= 1'b0;
      r_first <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_order <= w_order_nxt;
      r_ovf   <= w_ovf_nxt;
      r_first <= w_first_nxt;
    end
  end

  assign s.snk_ready = w_snk_rdy;
  assign s.src_valid = w_drain;
  assign s.src_sop   = w_drain && r_first;
  assign s.src_eop   = w_drain && (r_cnt == ONE);
  assign s.src_error = w_drain && (r_cnt == ONE) && r_ovf;
  assign s.src_data  = w_drain ? w_e[0] : '0;

`ifdef SORT_LENGTH_EN
  logic [CNT_W-1:0] r_len;

  // r_cnt counts down while draining, so the packet length is frozen on entry
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     r_len <= '0;
    else if (!w_drain) r_len <= w_cnt_nxt;
  end

  assign s.src_length = w_drain ? r_len : '0;
`endif

endmodule

// File: tb/tb_sort_stream.sv
// Scoreboard bench for sort_stream: expected sorted words queued at stimulus time, popped on src beats.
module tb_sort_stream;
  import sort_pkg::*;

  localparam int DW = 16;
  localparam int ML = 128;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  sort_stream_if #(
    .DATA_WIDTH(DW)
`ifdef SORT_LENGTH_EN
    , .MAX_LENGTH(ML)
`endif
  ) s ();

  sort_stream #(.DATA_WIDTH(DW), .MAX_LENGTH(ML)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .s      (s)
  );

  int nchk  = 0;
  int npass = 0;
  int unsigned exp_q[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic void push_sorted(input int unsigned w[$], input bit desc);
    int unsigned a[$];
    int unsigned v;
    int j;
    a = w;
    for (int i = 1; i < a.size(); i++) begin
      v = a[i];
      j = i;
      while (j > 0 && (desc ? (a[j-1] < v) : (a[j-1] > v))) begin
        a[j] = a[j-1];
        j--;
      end
      a[j] = v;
    end
    for (int i = 0; i < a.size() && i < ML; i++) exp_q.push_back(a[i]);
  endfunction

  task automatic send_beat(input int unsigned d, input bit sop, input bit eop, input bit ord);
    s.snk_valid  = 1'b1;
    s.snk_sop    = sop;
    s.snk_eop    = eop;
    s.snk_data   = DW'(d);
    s.sort_order = ord;
    tick();
    s.snk_valid = 1'b0;
    s.snk_sop   = 1'b0;
    s.snk_eop   = 1'b0;
  endtask

  task automatic send_pkt(input int unsigned w[$], input bit ord);
    for (int i = 0; i < w.size(); i++) begin
      if (i == w.size() - 1) begin
        nchk++;
        if (s.src_valid !== 1'b0 || s.snk_ready !== 1'b1)
          $display("FAIL load_state: src_valid=%b snk_ready=%b, expected src_valid=0 snk_ready=1",
                   s.src_valid, s.snk_ready);
        else npass++;
      end
      send_beat(w[i], i == 0, i == w.size() - 1, ord);
    end
    push_sorted(w, ord);
  endtask

  task automatic drain(input string name, input int n, input bit toggle, input bit exp_err,
                       input int exp_len);
    int got = 0;
    int cyc = 0;
    bit rdy = 1'b1;
    int unsigned e;
    nchk++;
    if (s.src_valid !== 1'b1)
      $display("FAIL %s_latency: src_valid=%b one cycle after eop, expected 1", name, s.src_valid);
    else npass++;
    while (got < n && cyc < 4 * ML) begin
      s.src_ready = rdy;
      if (s.src_valid === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q[0] : 0;
        nchk++;
        if (s.src_data !== DW'(e) || s.src_sop !== (got == 0) || s.src_eop !== (got == n - 1) ||
            s.src_error !== ((got == n - 1) && exp_err) || s.snk_ready !== 1'b0)
          $display("FAIL %s beat %0d: data=%h sop=%b eop=%b err=%b snk_ready=%b, expected data=%h sop=%b eop=%b err=%b snk_ready=0",
                   name, got, s.src_data, s.src_sop, s.src_eop, s.src_error, s.snk_ready,
                   DW'(e), (got == 0), (got == n - 1), ((got == n - 1) && exp_err));
        else npass++;
`ifdef SORT_LENGTH_EN
        nchk++;
        if (s.src_length !== (ML > 0 ? $bits(s.src_length)'(exp_len) : '0))
          $display("FAIL %s_length beat %0d: src_length=%0d, expected %0d", name, got,
                   s.src_length, exp_len);
        else npass++;
`endif
        if (rdy) begin
          void'(exp_q.pop_front());
          got++;
        end
      end
      tick();
      cyc++;
      if (toggle) rdy = !rdy;
    end
    s.src_ready = 1'b1;
    nchk++;
    if (got != n)
      $display("FAIL %s_count: %0d beats taken within bound, expected %0d", name, got, n);
    else npass++;
    nchk++;
    if (s.src_valid !== 1'b0 || s.snk_ready !== 1'b1 || exp_q.size() != 0)
      $display("FAIL %s_end: src_valid=%b snk_ready=%b queue_left=%0d, expected 0 1 0", name,
               s.src_valid, s.snk_ready, exp_q.size());
    else npass++;
  endtask

  task automatic test_reset();
    s.snk_valid = 0; s.snk_sop = 0; s.snk_eop = 0; s.snk_data = '0;
    s.sort_order = 0; s.src_ready = 1;
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    nchk++; if (s.snk_ready !== 1'b1) $display("FAIL rst_snk_ready: got %b, expected 1", s.snk_ready); else npass++;
    nchk++; if (s.src_valid !== 1'b0) $display("FAIL rst_src_valid: got %b, expected 0", s.src_valid); else npass++;
    nchk++; if (s.src_sop !== 1'b0) $display("FAIL rst_src_sop: got %b, expected 0", s.src_sop); else npass++;
    nchk++; if (s.src_eop !== 1'b0) $display("FAIL rst_src_eop: got %b, expected 0", s.src_eop); else npass++;
    nchk++; if (s.src_data !== '0) $display("FAIL rst_src_data: got %h, expected 0", s.src_data); else npass++;
    nchk++; if (s.src_error !== 1'b0) $display("FAIL rst_src_error: got %b, expected 0", s.src_error); else npass++;
  endtask

  task automatic test_ascending();
    send_pkt('{5, 3, 9, 3, 1}, SORT_ASC);
    drain("asc", 5, 1'b0, 1'b0, 5);
  endtask

  task automatic test_desc_stall();
    send_pkt('{5, 3, 9, 3, 1}, SORT_DESC);
    drain("desc_stall", 5, 1'b1, 1'b0, 5);
  endtask

  task automatic test_overflow();
    int unsigned w[$];
    for (int v = ML + 2; v >= 1; v--) w.push_back(v);
    send_pkt(w, SORT_ASC);
    drain("overflow", ML, 1'b0, 1'b1, ML);
  endtask

  task automatic test_single();
    send_pkt('{16'hBEEF}, SORT_ASC);
    drain("single", 1, 1'b0, 1'b0, 1);
  endtask

  task automatic test_restart();
    send_beat(42, 1'b0, 1'b0, SORT_ASC);
    nchk++;
    if (s.src_valid !== 1'b0 || s.snk_ready !== 1'b1)
      $display("FAIL stray_beat: src_valid=%b snk_ready=%b, expected 0 1", s.src_valid, s.snk_ready);
    else npass++;
    send_beat(7, 1'b1, 1'b0, SORT_ASC);
    send_beat(8, 1'b0, 1'b0, SORT_ASC);
    send_beat(2, 1'b1, 1'b0, SORT_ASC);
    send_beat(1, 1'b0, 1'b1, SORT_ASC);
    exp_q.push_back(1);
    exp_q.push_back(2);
    drain("restart", 2, 1'b0, 1'b0, 2);
  endtask

  task automatic test_reset_drain();
    send_pkt('{4, 2, 6}, SORT_ASC);
    s.src_ready = 1'b1;
    tick();
    reset_n = 1'b0;
    #1;
    nchk++;
    if (s.src_valid !== 1'b0 || s.snk_ready !== 1'b1 || s.src_sop !== 1'b0 || s.src_eop !== 1'b0)
      $display("FAIL mid_drain_reset: src_valid=%b snk_ready=%b sop=%b eop=%b, expected 0 1 0 0",
               s.src_valid, s.snk_ready, s.src_sop, s.src_eop);
    else npass++;
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    tick();
    send_pkt('{30, 10, 20}, SORT_DESC);
    drain("after_reset", 3, 1'b0, 1'b0, 3);
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_desc_stall();
    test_overflow();
    test_single();
    test_restart();
    test_reset_drain();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", npass, nchk);
    $fatal(1);
  end

endmodule

// File: doc/sort_stream.md
Name: sort_stream

Overview:
- Single-clock streaming packet sorter; next generation of the dual-clock sort_top.
- Accepts one packet of up to MAX_LENGTH words on a sink stream and sorts it on the fly in a systolic insertion array, one word per cycle.
- After eop, emits the sorted packet on a source stream with backpressure. Sort direction is selectable per packet.
- Overlong packets are handled: the MAX_LENGTH extreme words are kept and an error is flagged.

Parameters:
- DATA_WIDTH, 16, width of each data word (unsigned compare).
- MAX_LENGTH, 128, insertion-array depth; must be ≥2.
- CNT_W, $clog2(MAX_LENGTH)+1, derived; width of the element counter. Not to be overridden.

Ports:
- clock  in  1  single clock for the whole block.
- reset_n  in  1  asynchronous, active-low reset.
- snk_ready  out  1  block can accept a sink beat this cycle.
- snk_valid  in  1  sink beat valid.
- snk_sop  in  1  first word of packet.
- snk_eop  in  1  last word of packet.
- snk_data  in  DATA_WIDTH  sink word.
- sort_order  in  1  0 = ascending, 1 = descending; sampled on the accepted sop beat.
- src_ready  in  1  downstream accepts a source beat.
- src_valid  out  1  source beat valid.
- src_sop  out  1  first sorted word.
- src_eop  out  1  last sorted word.
- src_data  out  DATA_WIDTH  sorted word.
- src_error  out  1  packet was truncated; valid only on the src_eop beat.

Behaviour:
- Reset (async assert, sync release): state = IDLE; count = 0; all valid bits = 0; order = 0; ovf = 0.
  - Outputs: snk_ready = 1, src_valid = 0, src_sop = 0, src_eop = 0, src_data = 0, src_error = 0.
  - Reset mid-packet or mid-drain discards everything immediately.
- Sink beat accepted when snk_valid && snk_ready.
- FSM states: IDLE, LOAD, DRAIN.
  - IDLE (snk_ready = 1): accepted beat with sop → clear array, latch sort_order, insert word, count = 1. Go to LOAD, or to DRAIN if eop is on the same beat. Accepted beat without sop is dropped silently.
  - LOAD (snk_ready = 1): each accepted beat inserts a word.
    - eop → DRAIN next cycle.
    - sop while in LOAD → discard the partial packet and restart with this word as element 0.
  - DRAIN (snk_ready = 0): src_valid = 1 from the first DRAIN cycle, i.e. one cycle after the eop beat is accepted.
    - Head entry e[0] drives src_data.
    - On src_valid && src_ready: shift array toward e[0] and decrement count.
    - src_sop = 1 on the first beat of the packet only.
    - src_eop = 1 when count == 1.
    - After the eop beat is taken → IDLE; snk_ready = 1 on the following cycle.
    - Holding src_ready = 0 freezes all source outputs.
- Insertion, single cycle:
  - keep[i] = valid[i] && (order ? e[i] >= x : e[i] <= x).
  - New e[i] = e[i] if keep[i]; else x if (i == 0 || keep[i-1]); else e[i-1]. Valid bits shift the same way.
  - Equal keys keep arrival order (stable sort).
- Overflow (count == MAX_LENGTH at insert):
  - e[MAX_LENGTH-1] falls off and count stays saturated, so the MAX_LENGTH smallest (ascending) or largest (descending) words are kept.
  - ovf is set; src_error = ovf on the src_eop beat; ovf clears on return to IDLE.
- Single-word packet (sop & eop together): one source beat with src_sop = src_eop = 1.
- Throughput: 1 word/cycle in; 1 word/cycle out with src_ready high; no overlap between LOAD and DRAIN.

Optional Feature:
- Macro: SORT_LENGTH_EN.
- Defined: extra output port src_length (CNT_W bits) carries the number of words in the emitted packet, saturated at MAX_LENGTH. It is valid and held while src_valid is high and 0 otherwise.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package sort_pkg: state enum (IDLE, LOAD, DRAIN); order constants (SORT_ASC = 0, SORT_DESC = 1); a function computing CNT_W from MAX_LENGTH.
- One natural sub-module, sort_cell: a single array slot holding an entry and its valid bit. It outputs keep, takes the upstream entry/valid/keep, and supports insert, shift-out and clear. Generated MAX_LENGTH times in sort_stream.

Test Plan:
- Packet [5, 3, 9, 3, 1], sort_order = 0, src_ready = 1 → out 1, 3, 3, 5, 9; src_sop on the 1, src_eop on the 9; src_valid first high one cycle after the eop beat; src_error = 0.
- Same packet with sort_order = 1 and src_ready toggling 1/0 every cycle → 9, 5, 3, 3, 1 with outputs stable while stalled; snk_ready = 0 throughout drain.
- MAX_LENGTH + 2 words 130 down to 1, ascending → 128 words 1..128 out; src_error = 1 on eop; with SORT_LENGTH_EN, src_length = 128.
- Single word 0xBEEF with sop = eop = 1 → one beat 0xBEEF, src_sop = src_eop = 1.
- Data beat without sop in IDLE, then sop restart mid-LOAD (after [7, 8], new sop with [2, 1]) → only 1, 2 emitted.
- reset_n pulsed low during DRAIN → src_valid = 0 immediately; snk_ready = 1 after release; the next packet sorts correctly.
